// File: rtl/inst_stream_encoder.sv
// inst_stream_encoder: packs symbolic instruction fields (ADD, SUB, OR, LW,
// SW, BEQ) into RV32I words and writes them sequentially into IMEM.
// Optional feature macro: INST_ENC_HALT_LOOP_EN appends a beq x0,x0,0 halt
// word after the final instruction of each program.
module inst_stream_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [12:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] MAX_ADDR = '1;
    localparam logic [31:0]       HALT_WORD = 32'h0000_0063;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [1:0]          err_q, err_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                last_acc_q, last_acc_d;  // final tuple already consumed
    logic                ovf_q, ovf_d;            // wrote the top address mid-program
    logic                halt_q, halt_d;          // halt word still to be written
    logic                finish_q, finish_d;      // program ends at the next edge

    logic                enc_legal;
    logic [31:0]         enc_word;
    logic                accept;
    logic                at_max;

    assign accept = in_valid && in_ready;
    assign at_max = (ptr_q == MAX_ADDR);

    // Field packing for the supported opcodes; flags illegal ops and odd BEQ offsets
    always_comb begin
        enc_legal = 1'b1;
        enc_word  = 32'h0;
        unique case (in_op)
            3'd0: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
            3'd1: enc_word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
            3'd2: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, 7'b0110011};
            3'd3: enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
            3'd4: enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
            3'd5: begin
                enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                             in_imm[4:1], in_imm[11], 7'b1100011};
                enc_legal = !in_imm[0];
            end
            default: enc_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: start is only honoured outside RUN
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (start)    state_d = S_RUN;
            S_RUN:          if (finish_q) state_d = S_DONE;
            default:                      state_d = S_IDLE;
        endcase
    end

    // Status outputs derived from state and sticky flags
    always_comb begin
        in_ready = (state_q == S_RUN) && !last_acc_q && !ovf_q;
        busy     = (state_q == S_RUN) || we_q;
        done     = (state_q == S_DONE);
    end

    // Datapath: write-port staging, pointer/count advance and error tracking
    always_comb begin
        ptr_d      = ptr_q;
        count_d    = count_q;
        err_d      = err_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        last_acc_d = last_acc_q;
        ovf_d      = ovf_q;
        halt_d     = halt_q;
        finish_d   = 1'b0;
        if (state_q != S_RUN) begin
            if (start) begin
                ptr_d      = BASE;
                count_d    = '0;
                err_d      = 2'b00;
                last_acc_d = 1'b0;
                ovf_d      = 1'b0;
                halt_d     = 1'b0;
            end
        end else if (halt_q) begin
            we_d     = 1'b1;
            addr_d   = ptr_q;
            wdata_d  = HALT_WORD;
            count_d  = count_q + 1'b1;
            if (!at_max) ptr_d = ptr_q + 1'b1;
            halt_d   = 1'b0;
            finish_d = 1'b1;
        end else if (accept) begin
            if (in_last) last_acc_d = 1'b1;
            if (enc_legal) begin
                we_d    = 1'b1;
                addr_d  = ptr_q;
                wdata_d = enc_word;
                count_d = count_q + 1'b1;
                // The pointer saturates at the top so it never wraps onto the program start
                if (!at_max) ptr_d = ptr_q + 1'b1;
                if (at_max && !in_last) begin
                    err_d[1] = 1'b1;
                    ovf_d    = 1'b1;
                    finish_d = 1'b1;
                end
            end else begin
                err_d[0] = 1'b1;
            end
            if (in_last) begin
`ifdef INST_ENC_HALT_LOOP_EN
                // No room for the halt word once the top address has been used
                if (enc_legal && at_max) begin
                    err_d[1] = 1'b1;
                    finish_d = 1'b1;
                end else begin
                    halt_d = 1'b1;
                end
`else
                finish_d = 1'b1;
`endif
            end
        end
    end

    // Datapath registers; reset drops any pending write
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= BASE;
            count_q    <= '0;
            err_q      <= 2'b00;
            we_q       <= 1'b0;
            addr_q     <= BASE;
            wdata_q    <= 32'h0;
            last_acc_q <= 1'b0;
            ovf_q      <= 1'b0;
            halt_q     <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            last_acc_q <= last_acc_d;
            ovf_q      <= ovf_d;
            halt_q     <= halt_d;
            finish_q   <= finish_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;
    assign count     = count_q;

endmodule
